// File: rtl/mouse_cursor_overlay.sv
// -----------------------------------------------------------------------------
// mouse_cursor_overlay
//
// Mouse-cursor renderer and click-event source for the railway display.
// Once per frame the raw mouse position is latched and clamped to the visible
// area. A two-stage pixel pipeline then decides whether the pixel currently
// being drawn belongs to the cursor (disc, ring, crosshair or hidden). After a
// click the cursor is drawn enlarged for FLASH_FRAMES frames, and the click
// position is offered to the path-search controller over valid/ready.
//
// Ports:
//   Clk          system clock (50 MHz)
//   Reset_n      asynchronous active-low reset
//   frame_clk    frame strobe; its rising edge starts a new frame
//   DrawX/DrawY  pixel currently being drawn
//   XMOV_MOUSE   raw mouse x
//   YMOV_MOUSE   raw mouse y
//   btn_left     left-button level
//   mode         cursor shape: 0 disc, 1 ring, 2 crosshair, 3 hidden
//   is_mouse     pixel presented two cycles earlier is part of the cursor
//   click_valid  click event pending
//   click_x/y    clamped cursor position captured at the click
//   click_ready  consumer accepts the pending event
//   click_drop   one-cycle pulse: click lost because an event was pending
// -----------------------------------------------------------------------------
module mouse_cursor_overlay #(
  parameter int COORD_W      = 10,
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int RADIUS       = 4,
  parameter int CLICK_RADIUS = 6,
  parameter int FLASH_FRAMES = 8,
  parameter int Y_INVERT     = 1
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_clk,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  input  logic [COORD_W-1:0] XMOV_MOUSE,
  input  logic [COORD_W-1:0] YMOV_MOUSE,
  input  logic               btn_left,
  input  logic [1:0]         mode,
  output logic               is_mouse,
  output logic               click_valid,
  output logic [COORD_W-1:0] click_x,
  output logic [COORD_W-1:0] click_y,
  input  logic               click_ready,
  output logic               click_drop
);

  localparam int CW = COORD_W;
  localparam int SW = COORD_W + 1;        // signed coordinate difference width
  localparam int DW = 2 * SW;             // squared-distance width, overflow free
  localparam int FW = $clog2(FLASH_FRAMES + 1);

  localparam logic [CW-1:0]        H_MAX    = CW'(H_RES - 1);
  localparam logic [CW-1:0]        V_MAX    = CW'(V_RES - 1);
  localparam logic signed [SW-1:0] V_RES_S  = SW'(V_RES);
  localparam logic signed [SW-1:0] V_MAX_S  = SW'(V_RES - 1);
  localparam logic [CW-1:0]        R_IDLE   = CW'(RADIUS);
  localparam logic [CW-1:0]        R_CLICK  = CW'(CLICK_RADIUS);
  localparam logic [FW-1:0]        FLASH_LD = FW'(FLASH_FRAMES);

  // ---------------------------------------------------------------------------
  // Frame edge detection
  // ---------------------------------------------------------------------------
  logic frame_d_q;
  logic frame_rise_q;
  logic frame_rise_d;

  assign frame_rise_d = frame_clk & ~frame_d_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_d_q    <= 1'b0;
      frame_rise_q <= 1'b0;
    end else begin
      frame_d_q    <= frame_clk;
      frame_rise_q <= frame_rise_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-frame cursor state: clamped position, shape, button, flash counter
  // ---------------------------------------------------------------------------
  logic [CW-1:0]        cur_x_q, cur_x_d;
  logic [CW-1:0]        cur_y_q, cur_y_d;
  logic signed [SW-1:0] y_raw;
  logic [1:0]           mode_q;
  logic                 btn_q;
  logic                 press;
  logic [FW-1:0]        flash_q, flash_d;
  logic [CW-1:0]        r_cur;

  always_comb begin
    cur_x_d = (XMOV_MOUSE > H_MAX) ? H_MAX : XMOV_MOUSE;

    // y may go negative when inverted, so it is formed one bit wider and
    // clamped from both sides.
    if (Y_INVERT != 0) begin
      y_raw = V_RES_S - $signed({1'b0, YMOV_MOUSE});
    end else begin
      y_raw = $signed({1'b0, YMOV_MOUSE});
    end

    if (y_raw[SW-1]) begin
      cur_y_d = '0;
    end else if (y_raw > V_MAX_S) begin
      cur_y_d = V_MAX;
    end else begin
      cur_y_d = y_raw[CW-1:0];
    end
  end

  // Only one press can be seen per frame because the button is sampled only
  // at frame_rise; this also debounces the button.
  assign press = frame_rise_q & btn_left & ~btn_q;

  always_comb begin
    flash_d = flash_q;
    if (press) begin
      flash_d = FLASH_LD;
    end else if (frame_rise_q && (flash_q != '0)) begin
      flash_d = flash_q - FW'(1);
    end
  end

  assign r_cur = (flash_q != '0) ? R_CLICK : R_IDLE;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cur_x_q <= '0;
      cur_y_q <= '0;
      mode_q  <= 2'd0;
      btn_q   <= 1'b0;
      flash_q <= '0;
    end else begin
      flash_q <= flash_d;
      if (frame_rise_q) begin
        cur_x_q <= cur_x_d;
        cur_y_q <= cur_y_d;
        mode_q  <= mode;
        btn_q   <= btn_left;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Click event channel
  // ---------------------------------------------------------------------------
  logic          click_valid_q, click_valid_d;
  logic [CW-1:0] click_x_q, click_x_d;
  logic [CW-1:0] click_y_q, click_y_d;
  logic          click_drop_q, click_drop_d;
  logic          transfer;

  assign transfer = click_valid_q & click_ready;

  always_comb begin
    click_valid_d = click_valid_q & ~transfer;
    click_x_d     = click_x_q;
    click_y_d     = click_y_q;
    click_drop_d  = 1'b0;
    if (press) begin
      // A slot freed by a transfer in this same cycle can take the new event.
      if (!click_valid_q || transfer) begin
        click_valid_d = 1'b1;
        click_x_d     = cur_x_d;
        click_y_d     = cur_y_d;
      end else begin
        click_drop_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      click_valid_q <= 1'b0;
      click_x_q     <= '0;
      click_y_q     <= '0;
      click_drop_q  <= 1'b0;
    end else begin
      click_valid_q <= click_valid_d;
      click_x_q     <= click_x_d;
      click_y_q     <= click_y_d;
      click_drop_q  <= click_drop_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel pipeline, stage 1: signed offsets from the cursor centre
  // ---------------------------------------------------------------------------
  logic signed [SW-1:0] dx_q, dx_d;
  logic signed [SW-1:0] dy_q, dy_d;
  logic [CW-1:0]        r1_q;
  logic [1:0]           mode1_q;

  assign dx_d = $signed({1'b0, DrawX}) - $signed({1'b0, cur_x_q});
  assign dy_d = $signed({1'b0, DrawY}) - $signed({1'b0, cur_y_q});

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dx_q    <= '0;
      dy_q    <= '0;
      r1_q    <= '0;
      mode1_q <= 2'd0;
    end else begin
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      r1_q    <= r_cur;
      mode1_q <= mode_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel pipeline, stage 2: distance test per shape
  // ---------------------------------------------------------------------------
  logic [SW-1:0] adx, ady;
  logic [DW-1:0] adx_w, ady_w;
  logic [DW-1:0] d2;
  logic [CW-1:0] rm1;
  logic [DW-1:0] r_w, rm1_w;
  logic [DW-1:0] r_sq, rm1_sq;
  logic [SW-1:0] r_s;
  logic          hit;
  logic          is_mouse_q;

  always_comb begin
    // Magnitudes first: squaring them unsigned avoids sign handling in the
    // multiplier, and the crosshair test needs them anyway.
    adx    = dx_q[SW-1] ? SW'(-dx_q) : SW'(dx_q);
    ady    = dy_q[SW-1] ? SW'(-dy_q) : SW'(dy_q);
    adx_w  = {{(DW-SW){1'b0}}, adx};
    ady_w  = {{(DW-SW){1'b0}}, ady};
    d2     = adx_w * adx_w + ady_w * ady_w;

    rm1    = (r1_q == '0) ? '0 : r1_q - CW'(1);
    r_w    = {{(DW-CW){1'b0}}, r1_q};
    rm1_w  = {{(DW-CW){1'b0}}, rm1};
    r_sq   = r_w * r_w;
    rm1_sq = rm1_w * rm1_w;
    r_s    = {1'b0, r1_q};

    hit = 1'b0;
    case (mode1_q)
      2'd0:    hit = (d2 <= r_sq);
      // With r = 0 the lower bound is forced to 0, so the ring is empty.
      2'd1:    hit = (d2 > rm1_sq) && (d2 <= r_sq) && (r1_q != '0);
      2'd2:    hit = ((dx_q == '0) && (ady <= r_s)) ||
                     ((dy_q == '0) && (adx <= r_s));
      default: hit = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      is_mouse_q <= 1'b0;
    end else begin
      is_mouse_q <= hit;
    end
  end

  assign is_mouse    = is_mouse_q;
  assign click_valid = click_valid_q;
  assign click_x     = click_x_q;
  assign click_y     = click_y_q;
  assign click_drop  = click_drop_q;

endmodule

// File: tb/tb_mouse_cursor_overlay.sv
// -----------------------------------------------------------------------------
// Testbench for mouse_cursor_overlay. A default instance (Y_INVERT=1) is
// exercised with a vector table of position/mode/pixel cases plus directed
// sequences for clicks, flash timing, back-pressure and asynchronous reset.
// A second instance with Y_INVERT=0 shares the inputs for the non-inverted
// y-mapping cases.
// -----------------------------------------------------------------------------
module tb_mouse_cursor_overlay;

  localparam int CW = 10;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          frame_clk;
  logic [CW-1:0] DrawX, DrawY, XMOV_MOUSE, YMOV_MOUSE;
  logic          btn_left;
  logic [1:0]    mode;
  logic          click_ready;

  logic          is_mouse, click_valid, click_drop;
  logic [CW-1:0] click_x, click_y;
  logic          is_mouse2, click_valid2, click_drop2;
  logic [CW-1:0] click_x2, click_y2;

  int checks = 0;
  int errors = 0;

  always #10 Clk = ~Clk;

  mouse_cursor_overlay dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .DrawX(DrawX), .DrawY(DrawY),
    .XMOV_MOUSE(XMOV_MOUSE), .YMOV_MOUSE(YMOV_MOUSE),
    .btn_left(btn_left), .mode(mode),
    .is_mouse(is_mouse), .click_valid(click_valid),
    .click_x(click_x), .click_y(click_y),
    .click_ready(click_ready), .click_drop(click_drop)
  );

  mouse_cursor_overlay #(.Y_INVERT(0)) dut2 (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .DrawX(DrawX), .DrawY(DrawY),
    .XMOV_MOUSE(XMOV_MOUSE), .YMOV_MOUSE(YMOV_MOUSE),
    .btn_left(btn_left), .mode(mode),
    .is_mouse(is_mouse2), .click_valid(click_valid2),
    .click_x(click_x2), .click_y(click_y2),
    .click_ready(click_ready), .click_drop(click_drop2)
  );

  typedef struct {
    int xmov;
    int ymov;
    int md;
    int px;
    int py;
    int exp_hit;
  } vec_t;

  vec_t vecs[32];
  int   n_vec = 0;

  task automatic add_vec(input int xm, input int ym, input int md,
                         input int px, input int py, input int e);
    vecs[n_vec].xmov    = xm;
    vecs[n_vec].ymov    = ym;
    vecs[n_vec].md      = md;
    vecs[n_vec].px      = px;
    vecs[n_vec].py      = py;
    vecs[n_vec].exp_hit = e;
    n_vec++;
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
    end
  endtask

  // One clock: inputs change at the falling edge, outputs are sampled there.
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // Raise frame_clk and run to the cycle after the latch (click results visible).
  task automatic frame_start();
    frame_clk = 1'b1;
    step();
    step();
  endtask

  task automatic frame_end();
    frame_clk = 1'b0;
    step();
  endtask

  task automatic frame();
    frame_start();
    frame_end();
  endtask

  task automatic pix(input string name, input int x, input int y, input int e);
    DrawX = CW'(x);
    DrawY = CW'(y);
    step();
    step();
    chk(name, int'(is_mouse), e);
  endtask

  task automatic drain();
    click_ready = 1'b1;
    step();
    click_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n     = 1'b0;
    frame_clk   = 1'b0;
    DrawX       = '0;
    DrawY       = '0;
    XMOV_MOUSE  = '0;
    YMOV_MOUSE  = '0;
    btn_left    = 1'b0;
    mode        = 2'd0;
    click_ready = 1'b0;

    // Position/shape vectors: {xmov, ymov, mode, drawx, drawy, expected}
    add_vec(100, 380, 0, 100, 100, 1);
    add_vec(100, 380, 0, 104, 100, 1);
    add_vec(100, 380, 0, 105, 100, 0);
    add_vec(100, 380, 0, 103, 103, 0);   // d2 = 18 > 16
    add_vec(100, 380, 0, 102, 103, 1);   // d2 = 13
    add_vec( 50, 430, 1,  54,  50, 1);   // ring edge
    add_vec( 50, 430, 1,  50,  50, 0);   // ring centre
    add_vec( 50, 430, 1,  52,  53, 1);   // d2 = 13 in (9,16]
    add_vec( 50, 430, 2,  50,  46, 1);
    add_vec( 50, 430, 2,  51,  51, 0);
    add_vec( 50, 430, 2,  46,  50, 1);
    add_vec( 50, 430, 2,  50,  45, 0);
    add_vec( 50, 430, 3,  50,  50, 0);
    add_vec( 50, 430, 0,  50,  50, 1);
    add_vec(700,   0, 0, 639, 479, 1);   // clamped to (639,479)
    add_vec(700,   0, 0, 639, 474, 0);
    add_vec(700,   0, 0, 635, 479, 1);
    add_vec( 10, 600, 0,  10,   0, 1);   // cur_y clamped to 0
    add_vec( 10, 600, 0,  10,   5, 0);
    add_vec( 10, 600, 0,  10,   4, 1);

    repeat (3) @(negedge Clk);
    chk("rst_is_mouse", int'(is_mouse), 0);
    chk("rst_valid", int'(click_valid), 0);
    chk("rst_click_x", int'(click_x), 0);
    chk("rst_click_y", int'(click_y), 0);
    chk("rst_drop", int'(click_drop), 0);
    Reset_n = 1'b1;
    step();

    for (int i = 0; i < n_vec; i++) begin
      XMOV_MOUSE = CW'(vecs[i].xmov);
      YMOV_MOUSE = CW'(vecs[i].ymov);
      mode       = 2'(vecs[i].md);
      frame();
      pix($sformatf("vec%0d", i), vecs[i].px, vecs[i].py, vecs[i].exp_hit);
      $display("vec %0d mouse=(%0d,%0d) mode=%0d pix=(%0d,%0d) is_mouse=%0d exp=%0d",
               i, vecs[i].xmov, vecs[i].ymov, vecs[i].md, vecs[i].px, vecs[i].py,
               is_mouse, vecs[i].exp_hit);
    end

    // Two-cycle latency: hit pixel, then a miss pixel visible only 2 cycles later.
    XMOV_MOUSE = 10'd100; YMOV_MOUSE = 10'd380; mode = 2'd0;
    frame();
    pix("lat_hit", 100, 100, 1);
    DrawX = 10'd300; DrawY = 10'd300;
    step();
    chk("lat_cycle1", int'(is_mouse), 1);
    step();
    chk("lat_cycle2", int'(is_mouse), 0);
    $display("latency sequence done");

    // Mode change mid-frame waits for the next frame_rise.
    mode = 2'd3;
    pix("midframe_mode", 100, 100, 1);
    frame();
    pix("next_frame_mode", 100, 100, 0);
    $display("mid-frame mode sequence done");

    // Non-inverted y instance.
    XMOV_MOUSE = 10'd20; YMOV_MOUSE = 10'd10; mode = 2'd0;
    frame();
    DrawX = 10'd20; DrawY = 10'd10;
    step(); step();
    chk("yinv0_hit", int'(is_mouse2), 1);
    chk("yinv1_miss", int'(is_mouse), 0);
    YMOV_MOUSE = 10'd600;
    frame();
    DrawY = 10'd479;
    step(); step();
    chk("yinv0_clamp", int'(is_mouse2), 1);
    DrawY = 10'd0;
    step(); step();
    chk("yinv1_clamp0", int'(is_mouse), 1);
    $display("y mapping sequence done");

    // Click, hold, transfer, and flash duration.
    XMOV_MOUSE = 10'd200; YMOV_MOUSE = 10'd330; btn_left = 1'b0;
    frame();
    btn_left = 1'b1;
    frame_start();
    chk("click_valid", int'(click_valid), 1);
    chk("click_x", int'(click_x), 200);
    chk("click_y", int'(click_y), 150);
    chk("click_nodrop", int'(click_drop), 0);
    frame_end();
    pix("flash_r6_f0", 206, 150, 1);
    step(); step();
    chk("click_hold_valid", int'(click_valid), 1);
    chk("click_hold_x", int'(click_x), 200);
    chk("click_hold_y", int'(click_y), 150);
    drain();
    chk("click_xfer", int'(click_valid), 0);
    $display("click x=200 y=150 transferred");
    for (int k = 1; k <= 7; k++) begin
      frame();
      pix($sformatf("flash_r6_f%0d", k), 206, 150, 1);
    end
    frame();
    pix("flash_end_miss", 206, 150, 0);
    pix("flash_end_r4", 204, 150, 1);

    // Reload during flash.
    btn_left = 1'b0; frame();
    btn_left = 1'b1; frame(); drain();
    btn_left = 1'b0; frame(); frame();
    btn_left = 1'b1; frame();
    chk("reload_valid", int'(click_valid), 1);
    drain();
    for (int k = 1; k <= 7; k++) begin
      frame();
      pix($sformatf("reload_r6_f%0d", k), 206, 150, 1);
    end
    frame();
    pix("reload_end_miss", 206, 150, 0);
    $display("flash reload sequence done");

    // Back-pressure: second press dropped.
    click_ready = 1'b0;
    XMOV_MOUSE = 10'd300; YMOV_MOUSE = 10'd380;
    btn_left = 1'b0; frame();
    btn_left = 1'b1; frame_start();
    chk("bp_first_valid", int'(click_valid), 1);
    chk("bp_first_x", int'(click_x), 300);
    chk("bp_first_nodrop", int'(click_drop), 0);
    frame_end();
    XMOV_MOUSE = 10'd400;
    btn_left = 1'b0; frame();
    btn_left = 1'b1; frame_start();
    chk("bp_drop_pulse", int'(click_drop), 1);
    frame_end();
    chk("bp_drop_cleared", int'(click_drop), 0);
    chk("bp_keep_valid", int'(click_valid), 1);
    chk("bp_keep_x", int'(click_x), 300);
    chk("bp_keep_y", int'(click_y), 100);
    $display("back-pressure drop sequence done");

    // Press in the same cycle as a transfer: new event loads, no drop.
    XMOV_MOUSE = 10'd500;
    btn_left = 1'b0; frame();
    btn_left = 1'b1;
    frame_clk = 1'b1;
    step();
    click_ready = 1'b1;
    step();
    click_ready = 1'b0;
    chk("same_cycle_valid", int'(click_valid), 1);
    chk("same_cycle_x", int'(click_x), 500);
    chk("same_cycle_y", int'(click_y), 100);
    chk("same_cycle_nodrop", int'(click_drop), 0);
    frame_end();
    drain();
    chk("same_cycle_drained", int'(click_valid), 0);
    click_ready = 1'b1;
    step();
    chk("ready_idle_noeffect", int'(click_valid), 0);
    click_ready = 1'b0;
    $display("same-cycle transfer sequence done");

    // Asynchronous reset with event pending and flash active.
    XMOV_MOUSE = 10'd100; YMOV_MOUSE = 10'd380;
    btn_left = 1'b0; frame();
    btn_left = 1'b1; frame();
    chk("pre_rst_valid", int'(click_valid), 1);
    pix("pre_rst_hit", 100, 100, 1);
    #3;
    Reset_n = 1'b0;
    #1;
    chk("arst_is_mouse", int'(is_mouse), 0);
    chk("arst_valid", int'(click_valid), 0);
    chk("arst_x", int'(click_x), 0);
    chk("arst_y", int'(click_y), 0);
    chk("arst_drop", int'(click_drop), 0);
    @(negedge Clk);
    step();
    Reset_n = 1'b1;
    step(); step(); step();
    chk("post_rst_no_event", int'(click_valid), 0);
    btn_left = 1'b0;
    frame();
    chk("post_rst_frame_no_event", int'(click_valid), 0);
    pix("post_rst_flash_clear", 106, 100, 0);
    pix("post_rst_r4", 104, 100, 1);
    btn_left = 1'b1;
    frame();
    chk("post_rst_press_valid", int'(click_valid), 1);
    chk("post_rst_press_x", int'(click_x), 100);
    $display("async reset sequence done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mouse_cursor_overlay.md
# mouse_cursor_overlay

Parametrised mouse-cursor renderer and click-event source for the railway display. Latches the mouse position once per frame, clamps it to the visible area, and produces a pipelined per-pixel cursor hit signal in one of several shapes. The cursor enlarges for a configurable number of frames after a click. Each click is also delivered to the path-search controller as a coordinate event over a valid/ready handshake.

## Interface
Parameters:
- COORD_W, 10, width of all pixel coordinates
- H_RES, 640, visible width in pixels
- V_RES, 480, visible height in pixels
- RADIUS, 4, idle cursor radius in pixels
- CLICK_RADIUS, 6, cursor radius while flashing after a click
- FLASH_FRAMES, 8, number of frames the enlarged cursor is shown
- Y_INVERT, 1, 1: cursor y = V_RES − YMOV_MOUSE; 0: cursor y = YMOV_MOUSE

Ports:
- Clk  in  1  50 MHz system clock
- Reset_n  in  1  asynchronous, active-low reset
- frame_clk  in  1  frame strobe (~60 Hz); its rising edge marks a new frame
- DrawX, DrawY  in  COORD_W  current pixel being drawn
- XMOV_MOUSE, YMOV_MOUSE  in  COORD_W  raw mouse position
- btn_left  in  1  left-button level
- mode  in  2  shape select: 0 disc, 1 ring, 2 crosshair, 3 hidden
- is_mouse  out  1  current pixel belongs to the cursor (2-cycle latency)
- click_valid  out  1  click event pending
- click_x, click_y  out  COORD_W  clamped cursor position at the click
- click_ready  in  1  consumer accepts the event
- click_drop  out  1  one-cycle pulse: a click was lost because an event was already pending

## Operation
- Frame edge: frame_clk is registered into frame_d. frame_rise = frame_clk & ~frame_d, registered, giving a one-cycle pulse per frame. All cursor state below changes only on the cycle frame_rise is high.
- Position latch on frame_rise:
  - cur_x = min(XMOV_MOUSE, H_RES−1).
  - cur_y is computed signed in COORD_W+1 bits: V_RES−YMOV_MOUSE when Y_INVERT=1, otherwise YMOV_MOUSE. It is then clamped to [0, V_RES−1].
  - mode is latched into mode_q at the same time, so the shape never changes mid-frame.
- Button: btn_left is sampled into btn_q on frame_rise. A press is btn_left=1 with btn_q=0 at frame_rise, so only one press is detected per frame, which debounces the button.
- Flash counter (width clog2(FLASH_FRAMES+1)):
  - On a press, the counter loads FLASH_FRAMES. This takes priority over the decrement in the same frame.
  - Otherwise, on frame_rise the counter decrements if it is nonzero.
  - Active radius r = CLICK_RADIUS while the counter is nonzero, else RADIUS.
- Click event on a press:
  - Captured coordinates are the newly clamped cur_x/cur_y from the same frame_rise.
  - If click_valid=0, or the current event is being transferred this cycle (click_valid & click_ready): load click_x/click_y and set click_valid=1.
  - Otherwise the press is dropped, click_drop pulses for one cycle, and the pending event is left unchanged.
- Handshake: a transfer occurs on a Clk edge with click_valid & click_ready. click_valid clears after a transfer unless a new event loads in the same cycle. click_x/click_y stay stable while click_valid=1. click_ready may be high while click_valid is low; that has no effect.
- Pixel pipeline:
  - Stage 1 registers dx = DrawX−cur_x and dy = DrawY−cur_y, signed COORD_W+1 bits, together with r and mode_q.
  - Stage 2 computes d2 = dx²+dy² at 2(COORD_W+1) bits, which cannot overflow, and registers is_mouse:
    - mode 0 (disc): d2 ≤ r²
    - mode 1 (ring): (r−1)² < d2 ≤ r²
    - mode 2 (crosshair): (dx=0 and |dy|≤r) or (dy=0 and |dx|≤r)
    - mode 3 (hidden): 0
- Reset (Reset_n low, asynchronous) clears:
  - frame_d, frame_rise, btn_q, flash counter, cur_x, cur_y, mode_q (disc), both pipeline stages, is_mouse, click_valid, click_x, click_y, click_drop.
  - Reset mid-transfer discards the pending event. After Reset_n deasserts, no press is detected until the first frame_rise.

## Timing
- is_mouse reflects DrawX/DrawY presented 2 Clk cycles earlier. The VGA side delays its other pixel data by 2 cycles to match.
- Latency from frame_clk rising to the new cur_x/cur_y: 2 Clk cycles (frame_d, then frame_rise, then latch). The new position affects is_mouse 2 cycles after that.
- Latency from the press frame_rise to click_valid high: 1 cycle.
- Maximum event rate is one per frame, so a consumer that responds within one frame never causes a drop.

## Test plan
- Defaults, XMOV=100, YMOV=380, mode=0, one frame_clk pulse: is_mouse=1 for DrawX=100, DrawY=100 and for (104,100); 0 for (105,100) and for (103,103) (d2=18>16); 2-cycle latency checked.
- Clamping: XMOV=700, YMOV=0 → cur=(639,479); YMOV=600 → cur_y=0. With Y_INVERT=0 and YMOV=10 → cur_y=10.
- Modes at cur=(50,50), r=4: ring hits (54,50) but not (50,50); crosshair hits (50,46) but not (51,51); mode 3 gives is_mouse=0 everywhere. A mode change mid-frame has no effect until the next frame_rise.
- Click: btn_left rises before a frame_rise with cur=(200,150) → click_valid=1, click_x=200, click_y=150 held until click_ready. Radius is 6 for exactly 8 frames, then 4. A press during the flash reloads the counter to 8.
- Back-pressure: with click_ready=0, two presses in separate frames → the second raises click_drop for one cycle and click_x/click_y keep the first values. A press arriving in the same cycle as a transfer loads the new event with no drop.
- Asynchronous reset asserted while click_valid=1 and the flash counter is nonzero → all outputs are 0 immediately, without waiting for a Clk edge. After release, no event is generated until a new press edge at a frame_rise.
